// File: rtl/armleo_mem_pkg.sv
// Shared types and helpers for the self-clearing single-port memory.
// State enum and word-width helper used by the top and storage array.
package armleo_mem_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } mem_clear_state_t;

    function automatic int calc_width(input int lanes, input int granularity);
        return lanes * granularity;
    endfunction

endpackage

// File: rtl/armleo_mem_1rwm.sv
// Raw single-port storage: per-lane masked write, read-first registered read.
// Contents are never reset; only the read register is.
module armleo_mem_1rwm
    import armleo_mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 7,
    parameter int GRANULARITY = 8,
    parameter int LANES       = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DEPTH_LOG2-1:0]            address,
    input  logic                             read,
    output logic [LANES*GRANULARITY-1:0]     readdata,
    input  logic                             write,
    input  logic [LANES*GRANULARITY-1:0]     writedata,
    input  logic [LANES-1:0]                 writemask
);

    localparam int WIDTH = calc_width(LANES, GRANULARITY);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [WIDTH-1:0] readdata_d;
    logic [WIDTH-1:0] readdata_q;

    always_comb begin
        readdata_d = readdata_q;
        if (read) begin
            readdata_d = storage[address];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    // Nonblocking update keeps the same-cycle read returning the old word.
    always_ff @(posedge clk) begin
        if (write) begin
            for (int i = 0; i < LANES; i++) begin
                if (writemask[i]) begin
                    storage[address][i*GRANULARITY +: GRANULARITY] <=
                        writedata[i*GRANULARITY +: GRANULARITY];
                end
            end
        end
    end

    assign readdata = readdata_q;

endmodule

// File: rtl/armleo_mem_1rwm_init.sv
// Single-port memory with a clear engine that sweeps INIT_VALUE after reset
// or flush, then serves one read and/or masked write per cycle.
//
// state | meaning
// CLEAR | sweeping INIT_VALUE into storage[counter], user port ignored
// IDLE  | ready, user read/write passed to the array
module armleo_mem_1rwm_init
    import armleo_mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 7,
    parameter int GRANULARITY = 8,
    parameter int LANES       = 4,
    parameter logic [LANES*GRANULARITY-1:0] INIT_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    output logic                             ready,
    input  logic [DEPTH_LOG2-1:0]            address,
    input  logic                             read,
    output logic [LANES*GRANULARITY-1:0]     readdata,
    input  logic                             write,
    input  logic [LANES*GRANULARITY-1:0]     writedata,
    input  logic [LANES-1:0]                 writemask
);

    localparam int WIDTH = calc_width(LANES, GRANULARITY);

    mem_clear_state_t        state_d, state_q;
    logic [DEPTH_LOG2-1:0]   counter_d, counter_q;

    logic [DEPTH_LOG2-1:0]   mem_address;
    logic                    mem_read;
    logic                    mem_write;
    logic [WIDTH-1:0]        mem_writedata;
    logic [LANES-1:0]        mem_writemask;

    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        mem_address   = address;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_writedata = writedata;
        mem_writemask = writemask;
        case (state_q)
            CLEAR: begin
                mem_address   = counter_q;
                mem_write     = 1'b1;
                mem_writedata = INIT_VALUE;
                mem_writemask = '1;
                counter_d     = counter_q + 1'b1;
                // Terminate on the last address rather than relying on wrap.
                if (counter_q == {DEPTH_LOG2{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (flush) begin
                    state_d   = CLEAR;
                    counter_d = '0;
                end else begin
                    mem_read  = read;
                    mem_write = write;
                end
            end
            default: begin
                state_d   = CLEAR;
                counter_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    assign ready = (state_q == IDLE);

    armleo_mem_1rwm #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .GRANULARITY (GRANULARITY),
        .LANES       (LANES)
    ) u_storage (
        .clk       (clk),
        .rst       (rst),
        .address   (mem_address),
        .read      (mem_read),
        .readdata  (readdata),
        .write     (mem_write),
        .writedata (mem_writedata),
        .writemask (mem_writemask)
    );

endmodule

// File: tb/tb_armleo_mem_1rwm_init.sv
// Self-checking bench: behavioural model compared every cycle, plus literal
// expectations for clear timing and masked/read-first behaviour.
module tb_armleo_mem_1rwm_init;

    localparam int DEPTH = 128;
    localparam int W     = 32;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          ready;
    logic [6:0]    address;
    logic          read;
    logic [W-1:0]  readdata;
    logic          write;
    logic [W-1:0]  writedata;
    logic [3:0]    writemask;

    int checks   = 0;
    int failures = 0;

    armleo_mem_1rwm_init dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .ready     (ready),
        .address   (address),
        .read      (read),
        .readdata  (readdata),
        .write     (write),
        .writedata (writedata),
        .writemask (writemask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a sweep position while busy, an array of words otherwise.
    logic [W-1:0] m_mem   [DEPTH];
    bit           m_known [DEPTH];
    logic [W-1:0] m_rd;
    bit           m_rd_known = 0;
    bit           m_valid    = 0;
    bit           m_busy     = 1;
    int           m_pos      = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid    = 1;
            m_busy     = 1;
            m_pos      = 0;
            m_rd       = '0;
            m_rd_known = 1;
        end else if (m_valid) begin
            if (m_busy) begin
                m_mem[m_pos]   = '0;
                m_known[m_pos] = 1;
                m_pos++;
                if (m_pos == DEPTH) m_busy = 0;
            end else if (flush) begin
                m_busy = 1;
                m_pos  = 0;
            end else begin
                if (read) begin
                    m_rd       = m_mem[address];
                    m_rd_known = m_known[address];
                end
                if (write) begin
                    for (int i = 0; i < 4; i++)
                        if (writemask[i]) m_mem[address][i*8 +: 8] = writedata[i*8 +: 8];
                end
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("ready_model", {31'b0, ready}, {31'b0, !m_busy});
            if (m_rd_known) check("readdata_model", readdata, m_rd);
        end
    end

    // Called at a negedge: apply inputs, advance one edge, return at next negedge.
    task automatic cyc(input logic r, input logic w, input logic [6:0] a,
                       input logic [W-1:0] d, input logic [3:0] m, input logic f);
        read = r; write = w; address = a; writedata = d; writemask = m; flush = f;
        @(negedge clk);
        read = 0; write = 0; flush = 0;
    endtask

    // Counts edges until ready is seen high; the edge just taken counts as `start`.
    task automatic wait_ready(input string name, input int start, input int exp);
        int n;
        n = start;
        while (!ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, n, exp);
    endtask

    initial begin
        rst = 1; flush = 0; read = 0; write = 0;
        address = '0; writedata = '0; writemask = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_readdata", readdata, 32'd0);
        rst = 0;
        wait_ready("clear_edges", 0, 128);

        cyc(1, 0, 7'd0, 0, 0, 0);   check("init_rd0", readdata, 32'h0);
        cyc(1, 0, 7'd64, 0, 0, 0);  check("init_rd64", readdata, 32'h0);
        cyc(1, 0, 7'd127, 0, 0, 0); check("init_rd127", readdata, 32'h0);

        cyc(0, 1, 7'd5, 32'h11223344, 4'b1111, 0);
        cyc(0, 1, 7'd5, 32'hAABBCCDD, 4'b0101, 0);
        cyc(1, 0, 7'd5, 0, 0, 0);   check("mask_merge", readdata, 32'h11BB33DD);

        cyc(0, 1, 7'd9, 32'hDEADBEEF, 4'hF, 0);
        cyc(1, 1, 7'd9, 32'h12345678, 4'hF, 0); check("read_first", readdata, 32'hDEADBEEF);
        cyc(1, 0, 7'd9, 0, 0, 0);   check("write_visible", readdata, 32'h12345678);

        for (int i = 0; i < 10; i++) cyc(0, 1, 7'd9, 32'h0, 4'hF, 0);
        check("readdata_hold", readdata, 32'h12345678);
        cyc(1, 0, 7'd5, 32'h0, 4'h0, 0);
        cyc(0, 1, 7'd5, 32'hFFFFFFFF, 4'h0, 0);
        cyc(1, 0, 7'd5, 0, 0, 0);   check("mask_zero_noop", readdata, 32'h11BB33DD);

        cyc(0, 1, 7'd3, 32'hFFFFFFFF, 4'hF, 1);
        check("flush_ready_low", {31'b0, ready}, 32'd0);
        wait_ready("flush_edges", 1, 129);
        cyc(1, 0, 7'd3, 0, 0, 0);   check("flush_rd3", readdata, 32'h0);
        cyc(1, 0, 7'd9, 0, 0, 0);   check("flush_rd9", readdata, 32'h0);

        cyc(0, 1, 7'd20, 32'hCAFEF00D, 4'hF, 0);
        cyc(1, 0, 7'd20, 0, 0, 0);  check("pre_rst_rd", readdata, 32'hCAFEF00D);
        cyc(0, 0, 7'd0, 0, 0, 1);
        for (int i = 0; i < 50; i++)
            cyc($urandom_range(0, 1), $urandom_range(0, 1), 7'($urandom_range(0, 127)),
                $urandom, 4'($urandom_range(0, 15)), 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rst_mid_readdata", readdata, 32'h0);
        begin
            int n;
            n = 0;
            while (!ready && n < 1000) begin
                read = 1'($urandom_range(0, 1)); write = 1'($urandom_range(0, 1));
                address = 7'($urandom_range(0, 127)); writedata = $urandom; writemask = 4'hF;
                @(negedge clk);
                n++;
            end
            read = 0; write = 0;
            check("rst_mid_edges", n, 128);
        end
        check("clear_readdata_hold", readdata, 32'h0);
        cyc(1, 0, 7'd20, 0, 0, 0);  check("rst_clear_rd20", readdata, 32'h0);

        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 1), $urandom_range(0, 1), 7'($urandom_range(0, 15)),
                $urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 149) == 0));
        for (int i = 0; i < 300 && !ready; i++) @(negedge clk);
        for (int a = 0; a < 16; a++) cyc(1, 0, 7'(a), 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
